// File: rtl/mem_arbiter.sv
// Single-port memory sequencer/arbiter sharing one memory port between the CPU and a DMA requester.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_datasize,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        r,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_datasize,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_rdy,
    output logic [15:0] dma_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            gnt_dma_q, gnt_dma_d;
    logic            we_q, we_d;
    logic            size_q, size_d;
    logic            addr0_q, addr0_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [1:0]      mem_be_q, mem_be_d;
    logic [14:0]     mem_addr_q, mem_addr_d;
    logic [15:0]     mem_wdata_q, mem_wdata_d;
    logic [15:0]     cpu_rdata_q, cpu_rdata_d;
    logic [15:0]     dma_rdata_q, dma_rdata_d;

    logic            any_req;
    logic            pick_dma;
    logic            sel_we;
    logic            sel_size;
    logic [15:0]     sel_addr;
    logic [15:0]     sel_wdata;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_data;

    assign any_req = cpu_req | dma_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dma_q, last_dma_d;

    // On a tie the requester that was not granted last wins.
    assign pick_dma = dma_req & (~cpu_req | ~last_dma_q);

    always_comb begin
        last_dma_d = last_dma_q;
        if (state_q == StIdle && any_req) begin
            last_dma_d = pick_dma;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            last_dma_q <= 1'b1;
        end else begin
            last_dma_q <= last_dma_d;
        end
    end
`else
    assign pick_dma = dma_req & ~cpu_req;
`endif

    assign sel_we    = pick_dma ? dma_we       : cpu_we;
    assign sel_size  = pick_dma ? dma_datasize : cpu_datasize;
    assign sel_addr  = pick_dma ? dma_addr     : cpu_addr;
    assign sel_wdata = pick_dma ? dma_wdata    : cpu_wdata;

    assign rd_byte = addr0_q ? mem_rdata[15:8] : mem_rdata[7:0];
    assign rd_data = size_q ? mem_rdata : {{8{rd_byte[7]}}, rd_byte};

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StAccess;
            StAccess: if (cnt_q == '0) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        r       = (state_q == StDone) && !gnt_dma_q;
        dma_rdy = (state_q == StDone) && gnt_dma_q;
        busy    = (state_q != StIdle);
    end

    always_comb begin
        cnt_d       = cnt_q;
        gnt_dma_d   = gnt_dma_q;
        we_d        = we_q;
        size_d      = size_q;
        addr0_d     = addr0_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_dma_d   = pick_dma;
                    we_d        = sel_we;
                    size_d      = sel_size;
                    addr0_d     = sel_addr[0];
                    cnt_d       = CntW'(MEM_LAT - 1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    mem_be_d    = sel_size ? 2'b11 : (sel_addr[0] ? 2'b10 : 2'b01);
                    mem_addr_d  = sel_addr[15:1];
                    mem_wdata_d = sel_size ? sel_wdata : {sel_wdata[7:0], sel_wdata[7:0]};
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!we_q) begin
                        if (gnt_dma_q) begin
                            dma_rdata_d = rd_data;
                        end else begin
                            cpu_rdata_d = rd_data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            cnt_q       <= '0;
            gnt_dma_q   <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            addr0_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            gnt_dma_q   <= gnt_dma_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr0_q     <= addr0_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model, directed and random traffic.
module tb_mem_arbiter;

    localparam int unsigned L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_datasize = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0, dma_datasize = 1'b0;
    logic [15:0] dma_addr = '0, dma_wdata = '0;
    logic        r, dma_rdy, mem_en, mem_we, busy;
    logic [15:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [1:0]  mem_be;
    logic [14:0] mem_addr;
    logic [15:0] mem_rdata = '0;

    mem_arbiter #(.MEM_LAT(L)) dut (
        .clk_50      (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_datasize(cpu_datasize),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .r           (r),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_datasize(dma_datasize),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_rdy     (dma_rdy),
        .dma_rdata   (dma_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    // Memory device driven only by the DUT's strobes (plus a preload port).
    logic [15:0] mem [32768];
    bit          wr [32768];
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    function automatic logic [15:0] init_val(input logic [14:0] a);
        logic [15:0] x;
        x = {1'b0, a};
        return (x * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] mem_word(input logic [14:0] a);
        return wr[a] ? mem[a] : init_val(a);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] cur, input logic [15:0] wd,
                                          input logic [1:0] be);
        return {be[1] ? wd[15:8] : cur[15:8], be[0] ? wd[7:0] : cur[7:0]};
    endfunction

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
            wr[pre_addr]  <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= merge(mem_word(mem_addr), mem_wdata, mem_be);
            wr[mem_addr]  <= 1'b1;
        end
    end

    always @(negedge clk) mem_rdata <= mem_word(mem_addr);

    // Reference model state
    logic [15:0] ref_mem [32768];
    bit          m_active, m_dma, m_we, m_size, m_last_dma, m_rst_seen;
    bit          m_rdy_cpu, m_rdy_dma;
    int          m_start;
    logic [15:0] m_addr, m_wdata, e_cpu_rd, e_dma_rd;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sext(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    // Uses the inputs driven during the current cycle.
    task automatic model_arbitrate();
        if (reset) begin
            m_active   = 1'b0;
            e_cpu_rd   = '0;
            e_dma_rd   = '0;
            m_last_dma = 1'b1;
            m_rst_seen = 1'b1;
        end else begin
            m_rst_seen = 1'b0;
            if (!m_active && (cpu_req || dma_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                m_dma = cpu_req ? (dma_req && !m_last_dma) : 1'b1;
`else
                m_dma = !cpu_req;
`endif
                m_we       = m_dma ? dma_we : cpu_we;
                m_size     = m_dma ? dma_datasize : cpu_datasize;
                m_addr     = m_dma ? dma_addr : cpu_addr;
                m_wdata    = m_dma ? dma_wdata : cpu_wdata;
                m_start    = cyc;
                m_active   = 1'b1;
                m_last_dma = m_dma;
            end
        end
    endtask

    task automatic model_advance_and_compare();
        int          ph;
        bit          en_exp;
        logic [14:0] w;
        logic [15:0] v;
        logic [1:0]  be_exp;
        if (m_active && cyc == m_start + int'(L) + 2) m_active = 1'b0;
        ph = m_active ? cyc - m_start : 0;
        w  = m_addr[15:1];
        if (ph == int'(L) + 1) begin
            if (m_we) begin
                if (m_size) ref_mem[w] = m_wdata;
                else if (m_addr[0]) ref_mem[w][15:8] = m_wdata[7:0];
                else ref_mem[w][7:0] = m_wdata[7:0];
            end else begin
                v = ref_mem[w];
                if (!m_size) v = m_addr[0] ? sext(v[15:8]) : sext(v[7:0]);
                if (m_dma) e_dma_rd = v;
                else e_cpu_rd = v;
            end
        end
        en_exp    = (ph >= 1) && (ph <= int'(L));
        m_rdy_cpu = (ph == int'(L) + 1) && !m_dma;
        m_rdy_dma = (ph == int'(L) + 1) && m_dma;
        check("busy", {15'd0, busy}, {15'd0, ph != 0});
        check("mem_en", {15'd0, mem_en}, {15'd0, en_exp});
        check("mem_we", {15'd0, mem_we}, {15'd0, en_exp && m_we});
        check("r", {15'd0, r}, {15'd0, m_rdy_cpu});
        check("dma_rdy", {15'd0, dma_rdy}, {15'd0, m_rdy_dma});
        check("cpu_rdata", cpu_rdata, e_cpu_rd);
        check("dma_rdata", dma_rdata, e_dma_rd);
        if (en_exp) begin
            be_exp = m_size ? 2'b11 : (m_addr[0] ? 2'b10 : 2'b01);
            check("mem_addr", {1'b0, mem_addr}, {1'b0, w});
            check("mem_be", {14'd0, mem_be}, {14'd0, be_exp});
            check("mem_wdata", mem_wdata, m_size ? m_wdata : {m_wdata[7:0], m_wdata[7:0]});
        end
        if (m_rst_seen) begin
            check("rst_mem_addr", {1'b0, mem_addr}, 16'h0000);
            check("rst_mem_be", {14'd0, mem_be}, 16'h0000);
            check("rst_mem_wdata", mem_wdata, 16'h0000);
        end
    endtask

    task automatic tick();
        model_arbitrate();
        @(posedge clk);
        #1;
        cyc++;
        model_advance_and_compare();
    endtask

    task automatic preload(input logic [14:0] a, input logic [15:0] d);
        pre_we     = 1'b1;
        pre_addr   = a;
        pre_data   = d;
        ref_mem[a] = d;
    endtask

    // Directed single transfer with literal expectations for MEM_LAT = 2.
    task automatic run_txn(input string tag, input bit dma, input bit we, input bit size,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [14:0] wa_exp, input logic [1:0] be_exp,
                           input logic [15:0] wd_exp, input logic [15:0] rd_exp);
        if (dma) begin
            dma_we = we; dma_datasize = size; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_datasize = size; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        tick();
        pre_we = 1'b0;
        check({tag, "_en_c1"}, {15'd0, mem_en}, 16'd1);
        check({tag, "_we_c1"}, {15'd0, mem_we}, {15'd0, we});
        check({tag, "_addr_c1"}, {1'b0, mem_addr}, {1'b0, wa_exp});
        check({tag, "_be_c1"}, {14'd0, mem_be}, {14'd0, be_exp});
        check({tag, "_wdata_c1"}, mem_wdata, wd_exp);
        tick();
        check({tag, "_en_c2"}, {15'd0, mem_en}, 16'd1);
        tick();
        check({tag, "_rdy_c3"}, {15'd0, dma ? dma_rdy : r}, 16'd1);
        check({tag, "_other_rdy_c3"}, {15'd0, dma ? r : dma_rdy}, 16'd0);
        check({tag, "_rdata_c3"}, dma ? dma_rdata : cpu_rdata, rd_exp);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        check({tag, "_rdy_c4"}, {15'd0, r | dma_rdy}, 16'd0);
        check({tag, "_busy_c4"}, {15'd0, busy}, 16'd0);
    endtask

    task automatic new_cpu();
        cpu_we = 1'($urandom); cpu_datasize = 1'($urandom);
        cpu_addr = 16'h3000 + 16'($urandom_range(0, 127)); cpu_wdata = 16'($urandom);
        cpu_req = 1'b1;
    endtask

    task automatic new_dma();
        dma_we = 1'($urandom); dma_datasize = 1'($urandom);
        dma_addr = 16'h3000 + 16'($urandom_range(0, 127)); dma_wdata = 16'($urandom);
        dma_req = 1'b1;
    endtask

    initial begin
        int         n;
        int         n_dma;
        logic [3:0] order;
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(15'(i));
        m_active = 1'b0; m_last_dma = 1'b1; e_cpu_rd = '0; e_dma_rd = '0;
        m_addr = '0; m_wdata = '0; m_dma = 1'b0; m_we = 1'b0; m_size = 1'b0; m_start = 0;

        reset = 1'b1;
        repeat (3) tick();
        check("reset_r", {15'd0, r}, 16'd0);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_cpu_rdata", cpu_rdata, 16'h0000);
        reset = 1'b0;
        tick();

        preload(15'h1800, 16'hBEEF);
        run_txn("cpu_word_rd", 1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000,
                15'h1800, 2'b11, 16'h0000, 16'hBEEF);
        preload(15'h1800, 16'h80FF);
        run_txn("cpu_byte_hi", 1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000,
                15'h1800, 2'b10, 16'h0000, 16'hFF80);
        run_txn("cpu_byte_lo", 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000,
                15'h1800, 2'b01, 16'h0000, 16'hFFFF);
        run_txn("dma_byte_wr", 1'b1, 1'b1, 1'b0, 16'h4000, 16'h1234,
                15'h2000, 2'b01, 16'h3434, 16'h0000);

        // Both requesters held for four transfers.
        cpu_we = 1'b0; cpu_datasize = 1'b1; cpu_addr = 16'h3010; cpu_req = 1'b1;
        dma_we = 1'b0; dma_datasize = 1'b1; dma_addr = 16'h3020; dma_req = 1'b1;
        n = 0; n_dma = 0; order = 4'b0000;
        for (int i = 0; i < 4 * (int'(L) + 2); i++) begin
            tick();
            if (r) begin
                if (n < 4) order[n] = 1'b0;
                n++;
            end
            if (dma_rdy) begin
                if (n < 4) order[n] = 1'b1;
                n++;
                n_dma++;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        check("both_pulses", 16'(n), 16'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("both_order", {12'd0, order}, 16'h000A);
        check("both_dma_pulses", 16'(n_dma), 16'd2);
`else
        check("both_order", {12'd0, order}, 16'h0000);
        check("both_dma_pulses", 16'(n_dma), 16'd0);
`endif

        // Reset in the first ACCESS cycle of a CPU write.
        cpu_we = 1'b1; cpu_datasize = 1'b1; cpu_addr = 16'h5000; cpu_wdata = 16'hAAAA;
        cpu_req = 1'b1;
        tick();
        check("abort_en_c1", {15'd0, mem_en}, 16'd1);
        check("abort_we_c1", {15'd0, mem_we}, 16'd1);
        reset = 1'b1;
        tick();
        check("abort_en_c2", {15'd0, mem_en}, 16'd0);
        check("abort_we_c2", {15'd0, mem_we}, 16'd0);
        check("abort_busy_c2", {15'd0, busy}, 16'd0);
        check("abort_r_c2", {15'd0, r}, 16'd0);
        reset = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_r", {15'd0, r}, 16'd0);
        end

        // Randomized traffic from both requesters.
        for (int i = 0; i < 800; i++) begin
            tick();
            if (m_rdy_cpu) begin
                cpu_req = 1'b0;
                if ($urandom_range(0, 1) == 1) new_cpu();
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                new_cpu();
            end
            if (m_rdy_dma) begin
                dma_req = 1'b0;
                if ($urandom_range(0, 1) == 1) new_dma();
            end else if (!dma_req && $urandom_range(0, 2) == 0) begin
                new_dma();
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        repeat (int'(L) + 3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory sequencer and arbiter for the LC-3b core. Shares the one memory port between the CPU control unit (MAR/MDR path, ready line `r`) and a DMA requester. Runs each access for a fixed number of cycles, handles byte/word sizing, and returns a one-cycle ready pulse with read data to the granted requester.

## Interface
- `MEM_LAT`, 2: memory access cycles per transfer (≥1)
- `clk_50`  in  1  system clock; everything on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU access request; held until `r`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_datasize`  in  1  1 = word, 0 = byte
- `cpu_addr`  in  16  byte address
- `cpu_wdata`  in  16  write data; byte writes use [7:0]
- `r`  out  1  CPU ready pulse
- `cpu_rdata`  out  16  CPU read data
- `dma_req`, `dma_we`, `dma_datasize`, `dma_addr`, `dma_wdata`  in  1/1/1/16/16  DMA request fields, same meaning as the CPU fields
- `dma_rdy`  out  1  DMA ready pulse
- `dma_rdata`  out  16  DMA read data
- `mem_en`  out  1  memory enable
- `mem_we`  out  1  memory write strobe
- `mem_be`  out  2  byte lanes: [1] high byte, [0] low byte
- `mem_addr`  out  15  word address (= addr[15:1])
- `mem_wdata`  out  16  memory write data
- `mem_rdata`  in  16  memory read data; valid in last ACCESS cycle
- `busy`  out  1  high when state ≠ IDLE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any request is high, latch the winner's fields and grant ID. Set counter to MEM_LAT-1. Go to ACCESS. With no request, stay in IDLE.
- ACCESS: drive `mem_en`=1 and `mem_addr`/`mem_be`/`mem_wdata`. `mem_we` = latched we. Decrement the counter each cycle. When the counter is 0, register read data and go to DONE.
- DONE: pulse ready (`r` or `dma_rdy`) for exactly one cycle, then return to IDLE.
- Word access: `mem_be`=2'b11. `mem_wdata`=wdata. Read data is returned unchanged. addr[0] is ignored.
- Byte access: `mem_be`=2'b01 if addr[0]=0, else 2'b10. `mem_wdata`={wdata[7:0],wdata[7:0]}. Read data is the selected byte, sign-extended to 16 bits.
- `cpu_rdata`/`dma_rdata` update only on completion of a read by that requester. Otherwise they hold.
- Write completions also pulse ready. The rdata of that requester is unchanged.
- Requests are sampled only in IDLE. A request held through DONE is re-arbitrated in the following IDLE cycle.
- Reset values: state IDLE; `mem_en`, `mem_we`, `r`, `dma_rdy`, `busy` = 0; `mem_be` = 0; `mem_addr`, `mem_wdata`, `cpu_rdata`, `dma_rdata` = 0; round-robin pointer = "DMA last".
- Reset during ACCESS aborts the transfer. `mem_en`/`mem_we` are low in the next cycle and no ready pulse is issued.

## Timing
- Request seen high in IDLE at cycle 0.
- ACCESS occupies cycles 1..MEM_LAT.
- Ready pulse and valid rdata appear in cycle MEM_LAT+1.
- Back-to-back throughput is one transfer per MEM_LAT+2 cycles.
- Memory outputs are registered and change only on state entry.
- The requester must hold all request fields stable from request until it sees ready.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both requests are high in IDLE, the requester not granted last wins. The pointer updates on every grant.
- Undefined: fixed priority, CPU always wins. DMA may starve. The pointer logic is not compiled.

## Test plan
- CPU word read, addr 16'h3000, `mem_rdata`=16'hBEEF, MEM_LAT=2 -> `mem_en` high cycles 1-2, `mem_addr`=15'h1800, `r` high only in cycle 3, `cpu_rdata`=16'hBEEF.
- CPU byte read, addr 16'h3001, `mem_rdata`=16'h80FF -> `mem_be`=2'b10, `cpu_rdata`=16'hFF80. Repeat with addr 16'h3000 -> `mem_be`=2'b01, `cpu_rdata`=16'hFFFF.
- DMA byte write, addr 16'h4000, `dma_wdata`=16'h1234 -> `mem_we`=1, `mem_be`=2'b01, `mem_wdata`=16'h3434, `dma_rdy` pulses, `dma_rdata` unchanged.
- Both requests held high for 4 transfers -> with macro: grants CPU, DMA, CPU, DMA. Without macro: CPU all four, `dma_rdy` never pulses.
- `reset` asserted in the first ACCESS cycle of a CPU write -> `mem_en`=`mem_we`=0 in the next cycle, no `r` pulse, `busy`=0.
